imm_ext_pipe: RTL and testbench
===============================

// Module: imm_ext_pipe
// PURPOSE
//  Parametrised, pipelined immediate extender for the datapath decode stage. Accepts an
//  IN_W-bit immediate plus a 3-bit mode, produces an OUT_W-bit extended/shifted operand.
//  Valid/ready handshake on both sides with a 2-entry output buffer, so decode can stall
//  against execute without losing operands. Adds branch/jump shift modes and illegal-mode flagging.
// PARAMETERS
//  IN_W    16   immediate input width; legal range 2..OUT_W-2
//  OUT_W   32   extended output width; must satisfy OUT_W >= IN_W+2
//  CNT_W   8    width of saturating illegal-mode counter
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      synchronous clear of buffered entries (pipeline flush)
//  in_valid   in   1      input operand valid
//  in_ready   out  1      block can accept input this cycle
//  in_imm     in   IN_W   raw immediate
//  in_mode    in   3      extension mode (see BEHAVIOUR)
//  out_valid  out  1      head entry valid
//  out_ready  in   1      consumer accepts head this cycle
//  out_data   out  OUT_W  extended result of head entry
//  out_err    out  1      head entry was issued with an illegal mode
//  err_cnt    out  CNT_W  saturating count of accepted illegal-mode operands
// BEHAVIOUR
//  Modes (S = OUT_W-IN_W):
//   000 zero:   {S'b0, imm}
//   001 sign:   {S{imm[IN_W-1]}, imm}
//   010 upper:  imm << S (imm in top IN_W bits, zeros below)
//   011 branch: sign-extend then <<2, result truncated to OUT_W
//   100 jump:   zero-extend then <<2, result truncated to OUT_W
//   101..111 illegal: data = 0, err = 1
//  Handshake: push when in_valid & in_ready; pop when out_valid & out_ready.
//  Extension computed at push and stored; buffer holds 2 entries, FIFO order.
//  Latency: accepted operand appears on out_* the next cycle at the earliest; no
//   combinational path from in_* to out_* and none from out_ready to in_ready.
//  in_ready = (count < 2), registered-state only. out_valid = (count != 0).
//  Count rules: push only ->+1; pop only ->-1; push & pop same cycle -> unchanged,
//   new entry queued behind head. At count==2 push is impossible (in_ready=0).
//  Pointer wrap: 1-bit read/write pointers toggle mod 2.
//  out_data/out_err reflect head entry; hold stable while out_valid & !out_ready.
//  When out_valid=0, out_data=0 and out_err=0.
//  err_cnt: +1 on each push with illegal mode; saturates at 2^CNT_W-1; not cleared by flush.
//  flush: next cycle count=0, pointers=0, out_valid=0; any push in the flush cycle is
//   discarded (but still counted in err_cnt if illegal); flush overrides pop.
//  Reset (async, rst_n=0): count=0, pointers=0, err_cnt=0, out_valid=0, out_data=0,
//   out_err=0, in_ready=1 once rst_n deasserts. Mid-operation reset drops all entries.
// TESTING
//  1 IN_W=16,OUT_W=32: push 0x8001 modes 000/001/010 with out_ready=1 ->
//    0x00008001, 0xFFFF8001, 0x80010000, each one cycle after push.
//  2 Mode 011 imm 0xFFFF -> 0xFFFFFFFC; mode 100 imm 0xFFFF -> 0x0003FFFC.
//  3 Mode 110 imm 0x1234 -> out_data=0, out_err=1, err_cnt 0->1; 300 illegal pushes
//    with CNT_W=8 -> err_cnt holds 255.
//  4 out_ready=0, push A,B -> in_ready=0 after 2nd push; raise out_ready -> A then B
//    in order, in_ready=1 the cycle after A pops; out_data stable while stalled.
//  5 count=1, simultaneous push C & pop -> count stays 1, C emerges next; flush with
//    count=2 -> out_valid=0 next cycle, in_ready=1.
//  6 Assert rst_n=0 mid-stream with 2 entries -> outputs 0 immediately (async),
//    no stale entry emitted after release; re-run scenario 1 at IN_W=12,OUT_W=24.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: computes the extended operand at push time and
// holds results in a 2-entry FIFO with valid/ready on both sides.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int S = OUT_W - IN_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Returns {illegal, data}; illegal modes yield zero data.
  function automatic logic [OUT_W:0] extend(input logic [IN_W-1:0] imm, input logic [2:0] mode);
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    zext = {{S{1'b0}}, imm};
    sext = {{S{imm[IN_W-1]}}, imm};
    case (mode)
      3'b000:  extend = {1'b0, zext};
      3'b001:  extend = {1'b0, sext};
      3'b010:  extend = {1'b0, imm, {S{1'b0}}};
      3'b011:  extend = {1'b0, sext << 2};
      3'b100:  extend = {1'b0, zext << 2};
      default: extend = {1'b1, {OUT_W{1'b0}}};
    endcase
  endfunction

  logic [1:0][OUT_W-1:0] data_q, data_d;
  logic [1:0]            err_q, err_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic [OUT_W:0]        ext_s;
  logic                  push_s;
  logic                  pop_s;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign ext_s     = extend(in_imm, in_mode);
  assign err_cnt   = err_cnt_q;

  // Head entry presented only while valid, zero otherwise.
  always_comb begin
    if (out_valid) begin
      out_data = data_q[rd_ptr_q];
      out_err  = err_q[rd_ptr_q];
    end else begin
      out_data = {OUT_W{1'b0}};
      out_err  = 1'b0;
    end
  end

  // Next-state for FIFO storage, pointers, occupancy and illegal-mode counter.
  always_comb begin
    data_d    = data_q;
    err_d     = err_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    // Illegal pushes are counted even when a flush discards them.
    if (push_s && ext_s[OUT_W] && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push_s) begin
        data_d[wr_ptr_q] = ext_s[OUT_W-1:0];
        err_d[wr_ptr_q]  = ext_s[OUT_W];
        wr_ptr_d         = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      err_q     <= 2'b00;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      err_cnt_q <= {CNT_W{1'b0}};
    end else begin
      data_q    <= data_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: queue-based reference model checked every cycle, plus
// directed literal expectations and a second instance at IN_W=12, OUT_W=24.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [7:0]  err_cnt;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [11:0] b_in_imm;
  logic [2:0]  b_in_mode;
  logic        b_out_valid;
  logic [23:0] b_out_data;
  logic        b_out_err;
  logic [3:0]  b_err_cnt;

  int checks = 0;
  int errors = 0;

  logic [32:0] mq[$];
  int          mcnt;

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .err_cnt(err_cnt)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(24), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_imm(b_in_imm), .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(1'b1),
    .out_data(b_out_data), .out_err(b_out_err), .err_cnt(b_err_cnt)
  );

  // Extension from arithmetic: returns {illegal, data} for given widths.
  function automatic logic [32:0] model_ext(input longint imm, input int mode, input int iw, input int ow);
    longint mask;
    longint s_imm;
    longint v;
    mask  = (longint'(1) << ow) - 1;
    s_imm = (imm >= (longint'(1) << (iw - 1))) ? imm - (longint'(1) << iw) : imm;
    case (mode)
      0:       v = imm;
      1:       v = s_imm;
      2:       v = imm * (longint'(1) << (ow - iw));
      3:       v = s_imm * 4;
      4:       v = imm * 4;
      default: return {1'b1, 32'd0};
    endcase
    v = v & mask;
    return {1'b0, v[31:0]};
  endfunction

  // Reference model: a plain queue of {err, data} entries and an error counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt <= 0;
    end else begin
      if (in_valid && mq.size() < 2 && in_mode >= 3'd5 && mcnt < 255) mcnt <= mcnt + 1;
      if (flush) begin
        mq.delete();
      end else if (out_ready && mq.size() != 0) begin
        if (in_valid && mq.size() < 2) mq.push_back(model_ext(longint'(in_imm), int'(in_mode), 16, 32));
        mq.delete(0);
      end else if (in_valid && mq.size() < 2) begin
        mq.push_back(model_ext(longint'(in_imm), int'(in_mode), 16, 32));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("out_data", 64'(out_data), (mq.size() != 0) ? 64'(mq[0][31:0]) : 64'd0);
    chk("out_err", 64'(out_err), (mq.size() != 0) ? 64'(mq[0][32]) : 64'd0);
    chk("err_cnt", 64'(err_cnt), 64'(mcnt));
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) compare_all();
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [2:0] mode,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_imm    = imm;
    in_mode   = mode;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic drive_b(input logic v, input logic [11:0] imm, input logic [2:0] mode);
    b_in_valid = v;
    b_in_imm   = imm;
    b_in_mode  = mode;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    drive_b(1'b0, 12'h0, 3'd0);

    // Pin the model against hand-computed values.
    chk("model_sign", 64'(model_ext(64'h8001, 1, 16, 32)), 64'h0_FFFF8001);
    chk("model_branch", 64'(model_ext(64'hFFFF, 3, 16, 32)), 64'h0_FFFFFFFC);
    chk("model_jump", 64'(model_ext(64'hFFFF, 4, 16, 32)), 64'h0_0003FFFC);
    chk("model_upper24", 64'(model_ext(64'h801, 2, 12, 24)), 64'h0_00801000);

    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);

    // Basic modes, one cycle after push.
    drive(1'b1, 16'h8001, 3'd0, 1'b1, 1'b0); tick(); chk("s1_zero", 64'(out_data), 64'h00008001);
    drive(1'b1, 16'h8001, 3'd1, 1'b1, 1'b0); tick(); chk("s1_sign", 64'(out_data), 64'hFFFF8001);
    drive(1'b1, 16'h8001, 3'd2, 1'b1, 1'b0); tick(); chk("s1_upper", 64'(out_data), 64'h80010000);
    drive(1'b1, 16'hFFFF, 3'd3, 1'b1, 1'b0); tick(); chk("s2_branch", 64'(out_data), 64'hFFFFFFFC);
    drive(1'b1, 16'hFFFF, 3'd4, 1'b1, 1'b0); tick(); chk("s2_jump", 64'(out_data), 64'h0003FFFC);
    drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b0); tick();

    // Stall with two entries, then drain in order.
    drive(1'b1, 16'h0011, 3'd0, 1'b0, 1'b0); tick(); chk("s4_ready1", 64'(in_ready), 64'd1);
    drive(1'b1, 16'h0022, 3'd0, 1'b0, 1'b0); tick(); chk("s4_ready0", 64'(in_ready), 64'd0);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    tick(); chk("s4_stall_a", 64'(out_data), 64'h11);
    tick(); chk("s4_stall_b", 64'(out_data), 64'h11);
    drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
    tick(); chk("s4_pop_b", 64'(out_data), 64'h22); chk("s4_ready_back", 64'(in_ready), 64'd1);
    tick(); chk("s4_empty", 64'(out_valid), 64'd0);

    // Simultaneous push/pop at count 1, then flush at count 2.
    drive(1'b1, 16'h0099, 3'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0033, 3'd0, 1'b1, 1'b0); tick(); chk("s5_c_head", 64'(out_data), 64'h33);
    drive(1'b1, 16'h0044, 3'd0, 1'b0, 1'b0); tick(); chk("s5_full", 64'(in_ready), 64'd0);
    drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b1); tick();
    chk("s5_flush_valid", 64'(out_valid), 64'd0); chk("s5_flush_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset with two buffered entries.
    drive(1'b1, 16'h0066, 3'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0077, 3'd1, 1'b0, 1'b0); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("s6_async_valid", 64'(out_valid), 64'd0);
    chk("s6_async_data", 64'(out_data), 64'd0);
    chk("s6_async_err", 64'(out_err), 64'd0);
    drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
    tick();
    #2 rst_n = 1'b1;
    tick(); chk("s6_no_stale_a", 64'(out_valid), 64'd0);
    tick(); chk("s6_no_stale_b", 64'(out_valid), 64'd0);

    // Illegal mode, flush-discarded illegal push, then saturation.
    drive(1'b1, 16'h1234, 3'd6, 1'b1, 1'b0); tick();
    chk("s3_data", 64'(out_data), 64'd0); chk("s3_err", 64'(out_err), 64'd1);
    chk("s3_cnt", 64'(err_cnt), 64'd1);
    drive(1'b1, 16'h0055, 3'd7, 1'b1, 1'b1); tick();
    chk("flush_push_dropped", 64'(out_valid), 64'd0); chk("flush_push_cnt", 64'(err_cnt), 64'd2);
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 16'($urandom), 3'(5 + $urandom_range(0, 2)), 1'b1, 1'b0);
      tick();
    end
    chk("s3_saturate", 64'(err_cnt), 64'd255);
    drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b0); tick();

    // Reset again so the random phase also exercises counting up to saturation.
    #2 rst_n = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
      tick();
    end
    drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b0); tick();

    // Narrow instance: IN_W=12, OUT_W=24.
    drive_b(1'b1, 12'h801, 3'd0); tick(); chk("b_zero", 64'(b_out_data), 64'h000801);
    drive_b(1'b1, 12'h801, 3'd1); tick(); chk("b_sign", 64'(b_out_data), 64'hFFF801);
    drive_b(1'b1, 12'h801, 3'd2); tick(); chk("b_upper", 64'(b_out_data), 64'h801000);
    drive_b(1'b1, 12'hFFF, 3'd3); tick(); chk("b_branch", 64'(b_out_data), 64'hFFFFFC);
    drive_b(1'b0, 12'h0, 3'd0); tick(); chk("b_idle", 64'(b_out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
